// File: rtl/neuai_key_pkg.sv
// Shared types and constants for the push-button debounce slice.
package neuai_key_pkg;

  typedef enum logic [1:0] {
    KEY_IDLE         = 2'd0,
    KEY_PRESS_WAIT   = 2'd1,
    KEY_PRESSED      = 2'd2,
    KEY_RELEASE_WAIT = 2'd3
  } key_state_t;

  localparam int DCNT_W = 8;
  localparam int HCNT_W = 12;

  localparam logic [1:0] MODE_SLOW = 2'd0;
  localparam logic [1:0] MODE_MED  = 2'd1;
  localparam logic [1:0] MODE_FAST = 2'd2;
  localparam logic [1:0] MODE_OFF  = 2'd3;

  // Up/down step through the four breath profiles with wrap-around.
  function automatic logic [1:0] mode_step(input logic [1:0] mode,
                                           input logic up,
                                           input logic dn);
    logic [1:0] nxt;
    nxt = mode;
    if (up && !dn) begin
      nxt = (mode == MODE_OFF) ? MODE_SLOW : mode + 2'd1;
    end else if (dn && !up) begin
      nxt = (mode == MODE_SLOW) ? MODE_OFF : mode - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/neuai_key_fsm.sv
// One key: 2-flop synchronizer, debounce FSM and counters on the 1 ms tick.
// The hold counter and key_long exist only with NEUAI_KEY_LONG_PRESS_EN defined.
module neuai_key_fsm
  import neuai_key_pkg::*;
#(
  parameter int DEBOUNCE_MS    = 20,
  parameter int LONG_MS        = 1000,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic w_clk_1ms,
  input  logic w_rst,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam logic REL_LVL = (KEY_ACTIVE_LOW != 0);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_MS - 1);

  key_state_t  state;
  logic [1:0]  sync;
  logic [DCNT_W-1:0] dcnt;
  logic        key_on;

  // Normalised so that 1 always means pressed.
  assign key_on = sync[1] ^ REL_LVL;

`ifdef NEUAI_KEY_LONG_PRESS_EN
  localparam logic [HCNT_W-1:0] HOLD_MAX = HCNT_W'(LONG_MS);
  logic [HCNT_W-1:0] hcnt;
`else
  assign key_long = 1'b0;
`endif

  always_ff @(posedge w_clk_1ms or negedge w_rst) begin
    if (!w_rst) begin
      sync        <= {2{REL_LVL}};
      state       <= KEY_IDLE;
      dcnt        <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
`ifdef NEUAI_KEY_LONG_PRESS_EN
      hcnt        <= '0;
      key_long    <= 1'b0;
`endif
    end else begin
      sync        <= {sync[0], key_raw};
      key_press   <= 1'b0;
      key_release <= 1'b0;
`ifdef NEUAI_KEY_LONG_PRESS_EN
      key_long    <= 1'b0;
`endif
      case (state)
        KEY_IDLE: begin
          if (key_on) begin
            state <= KEY_PRESS_WAIT;
            dcnt  <= '0;
          end
        end
        KEY_PRESS_WAIT: begin
          if (!key_on) begin
            state <= KEY_IDLE;
          end else if (dcnt == DCNT_LAST) begin
            state     <= KEY_PRESSED;
            key_level <= 1'b1;
            key_press <= 1'b1;
`ifdef NEUAI_KEY_LONG_PRESS_EN
            hcnt      <= '0;
`endif
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        KEY_PRESSED: begin
          if (!key_on) begin
            state <= KEY_RELEASE_WAIT;
            dcnt  <= '0;
          end
`ifdef NEUAI_KEY_LONG_PRESS_EN
          else if (hcnt != HOLD_MAX) begin
            hcnt <= hcnt + 1'b1;
            // Fires only on the step into saturation, so once per hold.
            if (hcnt == HOLD_MAX - 1'b1) begin
              key_long <= 1'b1;
            end
          end
`endif
        end
        KEY_RELEASE_WAIT: begin
          if (key_on) begin
            state <= KEY_PRESSED;
          end else if (dcnt == DCNT_LAST) begin
            state       <= KEY_IDLE;
            key_level   <= 1'b0;
            key_release <= 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: state <= KEY_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/neuai_key_debounce.sv
// Debounced key events plus the breath-mode select for the LED breathing stage.
// Optional long-press support is built with NEUAI_KEY_LONG_PRESS_EN defined.
module neuai_key_debounce
  import neuai_key_pkg::*;
#(
  parameter int N_KEYS         = 3,
  parameter int DEBOUNCE_MS    = 20,
  parameter int LONG_MS        = 1000,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic              w_clk_1ms,
  input  logic              w_rst,
  input  logic [N_KEYS-1:0] w_key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic [1:0]        breath_mode
);

  localparam int KEY_UP   = 0;
  localparam int KEY_DN   = 1;
`ifdef NEUAI_KEY_LONG_PRESS_EN
  localparam int KEY_MODE = 2;
`endif

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    neuai_key_fsm #(
      .DEBOUNCE_MS   (DEBOUNCE_MS),
      .LONG_MS       (LONG_MS),
      .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
    ) u_fsm (
      .w_clk_1ms  (w_clk_1ms),
      .w_rst      (w_rst),
      .key_raw    (w_key_raw[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i])
    );
  end

  // Reacts to the registered press pulses, so it lags them by one tick.
  always_ff @(posedge w_clk_1ms or negedge w_rst) begin
    if (!w_rst) begin
      breath_mode <= MODE_SLOW;
    end else begin
`ifdef NEUAI_KEY_LONG_PRESS_EN
      if (key_long[KEY_MODE]) begin
        breath_mode <= MODE_SLOW;
      end else begin
        breath_mode <= mode_step(breath_mode, key_press[KEY_UP], key_press[KEY_DN]);
      end
`else
      breath_mode <= mode_step(breath_mode, key_press[KEY_UP], key_press[KEY_DN]);
`endif
    end
  end

endmodule

// File: tb/tb_neuai_key_debounce.sv
// Bench for neuai_key_debounce: vector table plus event scoreboard keyed by tick.
module tb_neuai_key_debounce;

  localparam int LAT = 23;
  localparam int LONG_MS = 1000;

  logic       clk;
  logic       w_rst;
  logic [2:0] w_key_raw;
  logic [2:0] key_level;
  logic [2:0] key_press;
  logic [2:0] key_release;
  logic [2:0] key_long;
  logic [1:0] breath_mode;

  logic [2:0]  held;
  logic [31:0] cyc;
  int          n_assert;
  int          n_fail;

  // Scoreboard entry: {tick, long[2:0], release[2:0], press[2:0]}
  logic [40:0] exp_q[$];

  typedef struct {
    logic [2:0] mask;
    int         hold;
    logic       accept;
    logic [1:0] exp_mode;
  } vec_t;
  vec_t vecs[9];

  assign w_key_raw = ~held;

  neuai_key_debounce #(
    .N_KEYS(3), .DEBOUNCE_MS(20), .LONG_MS(LONG_MS), .KEY_ACTIVE_LOW(1)
  ) dut (
    .w_clk_1ms  (clk),
    .w_rst      (w_rst),
    .w_key_raw  (w_key_raw),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .breath_mode(breath_mode)
  );

  // Clock and tick counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = '0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at tick %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_ev(input logic [31:0] c, input logic [8:0] ev);
    logic [40:0] e;
    int pos;
    pos = exp_q.size();
    for (int k = 0; k < exp_q.size(); k++) begin
      e = exp_q[k];
      if (e[40:9] == c) begin
        e[8:0] = e[8:0] | ev;
        exp_q[k] = e;
        return;
      end
      if (e[40:9] > c) begin
        pos = k;
        break;
      end
    end
    exp_q.insert(pos, {c, ev});
  endtask

  task automatic monitor();
    logic [8:0]  obs;
    logic [40:0] head;
    obs = {key_long, key_release, key_press};
    while (exp_q.size() > 0 && exp_q[0][40:9] < cyc) begin
      head = exp_q.pop_front();
      n_assert++;
      n_fail++;
      $display("FAIL missed_event: tick %0d expected %b, not seen", head[40:9], head[8:0]);
    end
    if (exp_q.size() > 0 && exp_q[0][40:9] == cyc) begin
      head = exp_q.pop_front();
      check("event", 32'(obs), 32'(head[8:0]));
    end else if (obs != 9'b0) begin
      check("spurious_event", 32'(obs), 32'd0);
    end
  endtask

  // Advance n ticks, landing on falling edges and scoring every tick.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      monitor();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"},   32'(key_level),   32'd0);
    check({tag, "_press"},   32'(key_press),   32'd0);
    check({tag, "_release"}, 32'(key_release), 32'd0);
    check({tag, "_long"},    32'(key_long),    32'd0);
    check({tag, "_mode"},    32'(breath_mode), 32'd0);
  endtask

  initial begin
    logic [31:0] t0;
    logic [1:0]  mode_exp;
    n_assert = 0;
    n_fail   = 0;
    held     = 3'b000;
    w_rst    = 1'b0;

    vecs[0] = '{mask: 3'b001, hold: 100, accept: 1'b1, exp_mode: 2'd1};
    vecs[1] = '{mask: 3'b010, hold: 19,  accept: 1'b0, exp_mode: 2'd1};
    vecs[2] = '{mask: 3'b001, hold: 100, accept: 1'b1, exp_mode: 2'd2};
    vecs[3] = '{mask: 3'b001, hold: 100, accept: 1'b1, exp_mode: 2'd3};
    vecs[4] = '{mask: 3'b001, hold: 100, accept: 1'b1, exp_mode: 2'd0};
    vecs[5] = '{mask: 3'b010, hold: 100, accept: 1'b1, exp_mode: 2'd3};
    vecs[6] = '{mask: 3'b011, hold: 100, accept: 1'b1, exp_mode: 2'd3};
    vecs[7] = '{mask: 3'b100, hold: 100, accept: 1'b1, exp_mode: 2'd3};
    vecs[8] = '{mask: 3'b010, hold: 40,  accept: 1'b1, exp_mode: 2'd2};

    // Reset state
    step(3);
    check_all_zero("reset");
    w_rst = 1'b1;
    step(5);

    // Vector table: press, hold, release, settle
    for (int v = 0; v < 9; v++) begin
      t0 = cyc;
      held = held | vecs[v].mask;
      if (vecs[v].accept) push_ev(t0 + LAT, {6'b0, vecs[v].mask});
      step(vecs[v].hold);
      check("level_held", 32'(key_level), vecs[v].accept ? 32'(vecs[v].mask) : 32'd0);
      held = held & ~vecs[v].mask;
      if (vecs[v].accept) push_ev(cyc + LAT, {3'b0, vecs[v].mask, 3'b0});
      step(40);
      check("level_released", 32'(key_level), 32'd0);
      check("mode_after", 32'(breath_mode), 32'(vecs[v].exp_mode));
    end

    // Bounce on key 1: toggle every 5 ticks for 60 ticks
    for (int k = 0; k < 12; k++) begin
      held[1] = ~held[1];
      step(5);
      check("bounce_level", 32'(key_level[1]), 32'd0);
    end
    held[1] = 1'b0;
    step(40);
    check("bounce_mode", 32'(breath_mode), 32'd2);

    // Long hold of key 2
    t0 = cyc;
    held[2] = 1'b1;
    push_ev(t0 + LAT, 9'b000_000_100);
`ifdef NEUAI_KEY_LONG_PRESS_EN
    push_ev(t0 + LAT + LONG_MS, 9'b100_000_000);
    mode_exp = 2'd0;
`else
    mode_exp = 2'd2;
`endif
    step(1100);
    check("long_level", 32'(key_level), 32'b100);
    check("long_mode", 32'(breath_mode), 32'(mode_exp));
    held[2] = 1'b0;
    push_ev(cyc + LAT, 9'b000_100_000);
    step(40);

    // Reset during key 0 press debounce while key 2 is accepted
    t0 = cyc;
    held[2] = 1'b1;
    push_ev(t0 + LAT, 9'b000_000_100);
    step(30);
    check("pre_reset_level", 32'(key_level), 32'b100);
    held[0] = 1'b1;
    step(13);
    w_rst = 1'b0;
    step(1);
    check_all_zero("mid_reset");
    step(2);
    w_rst = 1'b1;
    push_ev(cyc + LAT, 9'b000_000_101);
    step(LAT - 1);
    check("post_reset_no_early", 32'(key_level), 32'd0);
    step(17);
    check("post_reset_level", 32'(key_level), 32'b101);
    check("post_reset_mode", 32'(breath_mode), 32'd1);
    held = 3'b000;
    push_ev(cyc + LAT, 9'b000_101_000);
    step(40);
    check("final_level", 32'(key_level), 32'd0);

    step(5);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/neuai_key_debounce.md
# neuai_key_debounce

Debounces the board push-buttons and turns them into clean one-cycle press/release/long-press events plus a 2-bit breath-mode register. It sits directly upstream of the LED breathing stage. That stage reads `breath_mode` to select its breathing profile. Everything runs on the 1 ms tick clock, so one cycle equals 1 ms and all time constants are expressed in milliseconds.

## Interface
Parameters:
- `N_KEYS`, default 3: number of debounced keys (board keys 1..3; key 0 is the system reset).
- `DEBOUNCE_MS`, default 20: cycles of stable level required to accept a change (legal range 2..255).
- `LONG_MS`, default 1000: hold time in cycles for a long-press event (legal range > `DEBOUNCE_MS`, < 4096).
- `KEY_ACTIVE_LOW`, default 1: raw key level when pressed is 0.

Ports:
- `w_clk_1ms`, input, 1 bit: clock (1 kHz tick).
- `w_rst`, input, 1 bit: reset, asynchronous, active-low.
- `w_key_raw`, input, `N_KEYS` bits: raw, asynchronous button levels.
- `key_level`, output, `N_KEYS` bits: debounced level, 1 = pressed.
- `key_press`, output, `N_KEYS` bits: one-cycle pulse on an accepted press.
- `key_release`, output, `N_KEYS` bits: one-cycle pulse on an accepted release.
- `key_long`, output, `N_KEYS` bits: one-cycle pulse when a hold reaches `LONG_MS`.
- `breath_mode`, output, 2 bits: breath profile select for the downstream stage.

## Operation
**Input conditioning.** Each raw key passes through a 2-flop synchronizer, then is normalised so that 1 = pressed.

**Per-key FSM.** States are IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. There is an 8-bit debounce counter `dcnt` and a 12-bit hold counter `hcnt`.
- **IDLE:** if the synchronized key is pressed, go to PRESS_WAIT with `dcnt`=0.
- **PRESS_WAIT:**
  - Key released: return to IDLE; this is a bounce and produces no event.
  - Key still pressed and `dcnt`==`DEBOUNCE_MS`-1: go to PRESSED, set `key_level`=1, pulse `key_press`, clear `hcnt`.
  - Otherwise: increment `dcnt`.
- **PRESSED:**
  - Key released: go to RELEASE_WAIT with `dcnt`=0.
  - Key still pressed: `hcnt` increments, saturating at `LONG_MS`.
- **RELEASE_WAIT:**
  - Key pressed again: return to PRESSED with no new `key_press`; `hcnt` is preserved.
  - `dcnt`==`DEBOUNCE_MS`-1: go to IDLE, set `key_level`=0, pulse `key_release`.
  - Otherwise: increment `dcnt`.

**Breath mode** (key index 0 = up, 1 = down):
- `key_press[0]` alone: `breath_mode` increments, wrapping 3→0.
- `key_press[1]` alone: `breath_mode` decrements, wrapping 0→3.
- Both in the same cycle: no change.

**Reset.** Asserting `w_rst` at any time, including mid-debounce, forces every FSM to IDLE and clears both counters. All outputs go to 0: `key_level`, `key_press`, `key_release`, `key_long` and `breath_mode`. Synchronizer flops reset to the released level.

## Timing
- All outputs are registered; there is no combinational path from `w_key_raw`.
- Press latency: with the raw key stable from edge 0, `key_press` is high during the cycle after edge `DEBOUNCE_MS`+3 (23 ms at default). Release latency is identical.
- `breath_mode` updates on the same edge on which `key_press` is sampled high, i.e. one cycle after the pulse is visible.
- A glitch shorter than `DEBOUNCE_MS` cycles produces no event and leaves `key_level` unchanged.
- Pulse widths are exactly 1 cycle.
- `key_press` and `key_release` of the same key never overlap. Events on different keys are independent and may coincide.

## Configuration
- Macro `NEUAI_KEY_LONG_PRESS_EN`.
- **Defined:**
  - The `hcnt` counters exist.
  - `key_long[i]` pulses once on the cycle `hcnt` reaches `LONG_MS`, i.e. `LONG_MS` cycles after `key_press[i]`.
  - `key_long[2]` forces `breath_mode` to 0. This takes priority over same-cycle up/down presses.
- **Undefined:**
  - No hold counters are built.
  - `key_long` is tied to 0.
  - Key 2 only produces press/release events.

## Structure
- Shared package `neuai_key_pkg` holds:
  - the FSM state typedef: `KEY_IDLE`, `KEY_PRESS_WAIT`, `KEY_PRESSED`, `KEY_RELEASE_WAIT`;
  - the `dcnt` and `hcnt` widths;
  - the `breath_mode` encoding constants `MODE_SLOW`, `MODE_MED`, `MODE_FAST`, `MODE_OFF`.
- Sub-module `neuai_key_fsm` contains one key's synchronizer, FSM and counters. It is instantiated `N_KEYS` times with a generate loop. The top level holds only the `breath_mode` logic.

## Test plan
- **Clean press.** Hold `w_key_raw[0]`=0 for 100 cycles after reset (`DEBOUNCE_MS`=20). Required: `key_press[0]` high for exactly 1 cycle after edge 23, `key_level[0]`=1, `breath_mode` 0→1.
- **Bounce.** Toggle `w_key_raw[1]` every 5 cycles for 60 cycles, then release. Required: no `key_press`, no `key_release`, `key_level[1]` stays 0.
- **Wrap.** Give 4 accepted presses of key 0. Required: `breath_mode` goes 1,2,3,0. One press of key 1 from 0. Required: `breath_mode`=3.
- **Simultaneous.** Press keys 0 and 1 on the same cycle. Required: both `key_press` bits pulse together and `breath_mode` is unchanged.
- **Long press** (macro defined, `LONG_MS`=1000). Hold key 2 for 1100 cycles. Required: `key_long[2]` pulses exactly 1000 cycles after `key_press[2]`, then `breath_mode`=0. Without the macro, `key_long` stays 0.
- **Reset mid-debounce.** Assert `w_rst` 10 cycles into PRESS_WAIT, then release it with the key still held. Required: all outputs are 0 during reset, and a fresh 23-cycle latency applies afterwards.
